mod_det_seq_ctrl: RTL and testbench

//  Initiator side of the 4x4 determinant start/done handshake. Accepts 16 signed
//  8-bit elements serially (row-major a..p) on a valid/ready stream, presents them
//  in parallel to the determinant core, pulses start, waits for done, captures the
//  16-bit result and returns it on a valid/ready output stream. Sits between the

---
 rtl/mod_det_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_mod_det_seq_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_det_seq_ctrl.sv
// rtl/mod_det_seq_ctrl.sv - 4x4 determinant initiator: serial element load, start/done handshake, result stream
// Optional feature macro: MOD_DET_TIMEOUT_EN (bounded wait for det_done, error result on expiry)
module mod_det_seq_ctrl #(
    parameter int DATA_W = 8,
    parameter int RES_W  = 16
`ifdef MOD_DET_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 in_last,
    output logic [16*DATA_W-1:0] mat_flat,
    output logic                 det_start,
    input  logic                 det_done,
    input  logic [RES_W-1:0]     det_result,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [RES_W-1:0]     res_data,
    output logic                 err
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [3:0]          idx;
    logic [DATA_W-1:0]   load_buf [16];
    logic                accept;
    logic                last_slot;
    logic                frame_err;
    logic                frame_done;
    logic                timeout_hit;

    assign accept     = in_valid && in_ready;
    assign last_slot  = (idx == 4'd15);
    assign frame_err  = accept && (in_last != last_slot);
    assign frame_done = accept && in_last && last_slot;

`ifdef MOD_DET_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // A det_done arriving on the expiry cycle takes priority over the timeout.
    assign timeout_hit = (state == WAIT) && !det_done && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        det_start  = 1'b0;
        res_valid  = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (frame_done) begin
                    next_state = START;
                end
            end
            START: begin
                det_start  = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                if (det_done || timeout_hit) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    next_state = LOAD;
                end
            end
            default: next_state = LOAD;
        endcase
    end

    // Slots 0..14 are staged; the 16th element goes straight into mat_flat so the
    // core sees a whole matrix only once framing has been confirmed.
    always_ff @(posedge clk) begin
        if (accept && !last_slot) begin
            load_buf[idx] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= 4'd0;
            err      <= 1'b0;
            res_data <= '0;
            mat_flat <= '0;
        end else begin
            if (accept) begin
                if (frame_err) begin
                    idx <= 4'd0;
                    err <= 1'b1;
                end else begin
                    idx <= idx + 4'd1;
                end
            end else if (state == RESP && res_ready) begin
                idx <= 4'd0;
            end

            if (frame_done) begin
                for (int i = 0; i < 15; i++) begin
                    mat_flat[i*DATA_W +: DATA_W] <= load_buf[i];
                end
                mat_flat[15*DATA_W +: DATA_W] <= in_data;
            end

            if (state == WAIT) begin
                if (det_done) begin
                    res_data <= det_result;
                end else if (timeout_hit) begin
                    res_data <= {1'b1, {(RES_W-1){1'b0}}};
                    err      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mod_det_seq_ctrl.sv
// tb/tb_mod_det_seq_ctrl.sv - scoreboard bench for mod_det_seq_ctrl with a determinant core stub
module tb_mod_det_seq_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = '0;
    logic         in_last = 1'b0;
    logic [127:0] mat_flat;
    logic         det_start;
    logic         det_done = 1'b0;
    logic [15:0]  det_result = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [15:0]  res_data;
    logic         err;

    mod_det_seq_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .mat_flat   (mat_flat),
        .det_start  (det_start),
        .det_done   (det_done),
        .det_result (det_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .err        (err)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fails = 0;
    logic [15:0]  exp_q[$];
    logic [127:0] mat_q[$];
    int           starts_seen = 0;
    int           n_sent = 0;
    bit           stub_hang = 1'b0;
    int           rr_mode = 2;
    int           cur_m[16];
    int           s0;
    int           t;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_fails++;
        $display("FAIL %s: bound expired or unexpected event", nm);
    endtask

    // Reference: cofactor expansion along the first row, full precision, then truncated.
    function automatic longint det4(input int m[16]);
        longint d;
        d = 0;
        for (int c = 0; c < 4; c++) begin
            int     s[9];
            int     k;
            longint d3;
            k = 0;
            for (int r = 1; r < 4; r++) begin
                for (int cc = 0; cc < 4; cc++) begin
                    if (cc != c) begin
                        s[k] = m[r*4 + cc];
                        k++;
                    end
                end
            end
            d3 = longint'(s[0]) * (s[4]*s[8] - s[5]*s[7])
               - longint'(s[1]) * (s[3]*s[8] - s[5]*s[6])
               + longint'(s[2]) * (s[3]*s[7] - s[4]*s[6]);
            if (c % 2 == 0) d = d + longint'(m[c]) * d3;
            else            d = d - longint'(m[c]) * d3;
        end
        return d;
    endfunction

    function automatic logic [127:0] pack(input int m[16]);
        logic [127:0] p;
        for (int i = 0; i < 16; i++) p[i*8 +: 8] = 8'(m[i]);
        return p;
    endfunction

    task automatic set_diag(input int a, input int b, input int c, input int d);
        for (int i = 0; i < 16; i++) cur_m[i] = 0;
        cur_m[0] = a; cur_m[5] = b; cur_m[10] = c; cur_m[15] = d;
    endtask

    task automatic set_rand();
        for (int i = 0; i < 16; i++) cur_m[i] = $urandom_range(0, 255) - 128;
    endtask

    task automatic push_model();
        longint d;
        d = det4(cur_m);
        exp_q.push_back(d[15:0]);
    endtask

    task automatic send_frame(input int n, input int last_at, input bit gaps);
        for (int i = 0; i < n; i++) begin
            bit acc;
            int cnt;
            acc = 1'b0;
            cnt = 0;
            in_valid = 1'b1;
            in_data  = 8'(cur_m[i]);
            in_last  = (i == last_at);
            while (!acc && cnt < 500) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                cnt++;
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (!acc) fail_now("element_accept");
            if (gaps && i < n - 1) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic send_core(input bit gaps);
        mat_q.push_back(pack(cur_m));
        send_frame(16, 15, gaps);
        @(negedge clk);
        check("det_start_after_16th", det_start, 1);
        check("in_ready_low_after_16th", in_ready, 0);
        n_sent++;
    endtask

    task automatic drain();
        int cnt;
        cnt = 0;
        while (exp_q.size() > 0 && cnt < 2000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        if (exp_q.size() > 0) fail_now("drain_results");
    endtask

    // Core stub: checks the matrix it is handed, answers after a random latency,
    // and throws spurious det_done pulses while idle that the controller must ignore.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            det_done = 1'b0;
            if (det_start) begin
                int           mm[16];
                logic [127:0] em;
                longint       d;
                if (mat_q.size() == 0) begin
                    fail_now("unexpected_det_start");
                end else begin
                    em = mat_q.pop_front();
                    check("mat_flat", mat_flat, em);
                end
                for (int i = 0; i < 16; i++) mm[i] = int'($signed(mat_flat[i*8 +: 8]));
                d = det4(mm);
                repeat ($urandom_range(1, 7)) begin
                    @(posedge clk);
                    #1;
                end
                if (!stub_hang) begin
                    det_done   = 1'b1;
                    det_result = d[15:0];
                end
            end else if (!stub_hang && $urandom_range(0, 5) == 0) begin
                det_done   = 1'b1;
                det_result = 16'($urandom);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rr_mode == 0) res_ready = ($urandom_range(0, 2) != 0);
        end
    end

    always @(negedge clk) begin
        if (det_start) starts_seen++;
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_result");
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check("res_data", res_data, e);
            end
        end
    end

    initial begin
        res_ready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_det_start", det_start, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_mat_flat", mat_flat, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rr_mode = 0;

        set_diag(1, 1, 1, 1);
        exp_q.push_back(16'h0001);
        send_core(0);
        drain();
        check("err_after_identity", err, 0);

        set_diag(2, 3, 4, 5);
        exp_q.push_back(16'd120);
        send_core(1);
        set_diag(-1, 1, 1, 1);
        exp_q.push_back(16'hFFFF);
        send_core(0);
        drain();

        rr_mode = 2;
        #0 res_ready = 1'b0;
        rr_mode = 1;
        set_rand();
        push_model();
        send_core(0);
        t = 0;
        while (!res_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!res_valid) fail_now("stall_wait_res_valid");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_res_valid", res_valid, 1);
            check("stall_in_ready", in_ready, 0);
            if (exp_q.size() > 0) check("stall_res_data", res_data, exp_q[0]);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_in_ready", in_ready, 1);
        check("release_res_valid", res_valid, 0);
        rr_mode = 0;
        set_rand();
        push_model();
        send_core(0);
        drain();

        set_rand();
        send_frame(7, -1, 0);
        s0 = starts_seen;
        rst_n = 1'b0;
        #1;
        check("midreset_in_ready", in_ready, 1);
        check("midreset_res_valid", res_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_diag(1, 1, 1, 1);
        exp_q.push_back(16'h0001);
        send_core(1);
        drain();
        check("midreset_single_start", starts_seen, s0 + 1);

`ifdef MOD_DET_TIMEOUT_EN
        stub_hang = 1'b1;
        set_rand();
        exp_q.push_back(16'h8000);
        send_core(0);
        t = 0;
        while (!res_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("timeout_latency", t, 65);
        check("timeout_err", err, 1);
        drain();
        stub_hang = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("timeout_err_cleared", err, 0);
`endif

        check("err_before_framing", err, 0);
        s0 = starts_seen;
        set_rand();
        send_frame(5, 4, 0);
        @(negedge clk);
        check("early_last_err", err, 1);
        repeat (5) @(posedge clk);
        #1;
        check("early_last_no_start", starts_seen, s0);
        send_frame(16, -1, 0);
        repeat (5) @(posedge clk);
        #1;
        check("missing_last_no_start", starts_seen, s0);
        check("framing_in_ready", in_ready, 1);
        set_rand();
        push_model();
        send_core(0);
        drain();
        check("err_sticky", err, 1);

        for (int n = 0; n < 20; n++) begin
            set_rand();
            push_model();
            send_core(1);
        end
        drain();
        repeat (5) @(posedge clk);
        check("total_starts", starts_seen, n_sent);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
